// File: rtl/controle_busca_instrucao.sv
// Instruction-fetch sequencer: owns the PC, waits out the memory read latency and hands
// the latched instruction to decode. Optional fetch counter under `CONTADOR_BUSCAS_EN`.
module controle_busca_instrucao #(
  parameter int unsigned                 LARGURA_END      = 8,
  parameter int unsigned                 LARGURA_INSTR    = 8,
  parameter logic [LARGURA_END-1:0]      ENDERECO_INICIAL = 8'h00,
  parameter int unsigned                 LATENCIA_MEM     = 1,
  parameter logic [LARGURA_INSTR-1:0]    OPCODE_PARADA    = 8'hFF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  output logic [LARGURA_END-1:0]   Endereco,
  input  logic [LARGURA_INSTR-1:0] Instrucao,
  output logic [LARGURA_INSTR-1:0] RegInstrucao,
  output logic [LARGURA_END-1:0]   PC,
  output logic                     InstrucaoValida,
  input  logic                     Aceita,
  input  logic                     Desvio,
  input  logic [LARGURA_END-1:0]   AlvoDesvio,
  output logic                     Parado
`ifdef CONTADOR_BUSCAS_EN
  ,
  output logic [15:0]              NumBuscas
`endif
);

  typedef enum logic [1:0] {INICIO, BUSCA, ENTREGA, PARADO} estado_t;

  localparam logic [1:0] LAT_FIM = 2'(LATENCIA_MEM);

  estado_t                  r_estado, w_prox;
  logic [1:0]               r_cont;
  logic [LARGURA_END-1:0]   r_end, r_pc;
  logic [LARGURA_INSTR-1:0] r_ri;
  logic                     r_valida, r_parado;
  logic                     w_fim_busca, w_entrega, w_parada;

  assign w_parada = (r_ri == OPCODE_PARADA);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_estado <= INICIO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox      = r_estado;
    w_fim_busca = 1'b0;
    w_entrega   = 1'b0;
    case (r_estado)
      INICIO:  w_prox = BUSCA;
      BUSCA: begin
        if (r_cont == LAT_FIM) begin
          w_fim_busca = 1'b1;
          w_prox      = ENTREGA;
        end
      end
      ENTREGA: begin
        if (r_valida && Aceita) begin
          w_entrega = 1'b1;
          w_prox    = w_parada ? PARADO : BUSCA;
        end
      end
      default: w_prox = PARADO;
    endcase
  end

  // Counter restarts at 0 on every entry into BUSCA, so BUSCA lasts LATENCIA_MEM+1 cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cont   <= '0;
      r_end    <= ENDERECO_INICIAL;
      r_pc     <= ENDERECO_INICIAL;
      r_ri     <= '0;
      r_valida <= 1'b0;
      r_parado <= 1'b0;
    end else begin
      if (r_estado == BUSCA && !w_fim_busca) r_cont <= r_cont + 2'd1;
      else                                   r_cont <= '0;
      if (w_fim_busca) begin
        r_ri     <= Instrucao;
        r_pc     <= r_end;
        r_valida <= 1'b1;
      end
      if (w_entrega) begin
        r_valida <= 1'b0;
        if (w_parada)    r_parado <= 1'b1;
        else if (Desvio) r_end    <= AlvoDesvio;
        else             r_end    <= r_pc + LARGURA_END'(1);
      end
    end
  end

`ifdef CONTADOR_BUSCAS_EN
  logic [15:0] r_num;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                        r_num <= '0;
    else if (w_entrega && r_num != '1) r_num <= r_num + 16'd1;
  end
  assign NumBuscas = r_num;
`endif

  assign Endereco        = r_end;
  assign PC              = r_pc;
  assign RegInstrucao    = r_ri;
  assign InstrucaoValida = r_valida;
  assign Parado          = r_parado;

endmodule
